// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Shared by div_step and div_unit.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  function automatic logic [DIV_WIDTH-1:0] neg_if(
    input logic [DIV_WIDTH-1:0] v,
    input logic                 n
  );
    return n ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Purely combinational.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic [DIV_WIDTH-1:0] quo,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] rem_nxt,
  output logic [DIV_WIDTH-1:0] quo_nxt
);

  logic [DIV_WIDTH:0] shl;
  logic [DIV_WIDTH:0] diff;

  // shl needs the extra bit: rem may reach divisor-1 before the shift
  assign shl  = {rem, quo[DIV_WIDTH-1]};
  assign diff = shl - {1'b0, divisor};

  always_comb begin
    rem_nxt = shl[DIV_WIDTH-1:0];
    quo_nxt = {quo[DIV_WIDTH-2:0], 1'b0};
    if (!diff[DIV_WIDTH]) begin
      rem_nxt    = diff[DIV_WIDTH-1:0];
      quo_nxt[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// 32-bit iterative DIV/DIVU unit (quotient on Lo, remainder on Hi).
// Define DIV_SIGNED_EN to honour the Signed input.
module div_unit
  import div_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Signed,
  input  logic [DIV_WIDTH-1:0] A,
  input  logic [DIV_WIDTH-1:0] B,
  output logic [DIV_WIDTH-1:0] Lo,
  output logic [DIV_WIDTH-1:0] Hi,
  output logic                 Busy,
  output logic                 Done,
  output logic                 DivZero
);

  div_state_t state, state_nxt;

  logic [5:0]           cnt;
  logic [DIV_WIDTH-1:0] rem, quo, dvsr;
  logic [DIV_WIDTH-1:0] rem_nxt, quo_nxt;
  logic [DIV_WIDTH-1:0] a_mag, b_mag;
  logic [DIV_WIDTH-1:0] res_lo, res_hi;
  logic                 dz;
  logic                 b_zero;

  assign b_zero = (B == '0);

`ifdef DIV_SIGNED_EN
  logic sa, sb, neg_q, neg_r;

  assign sa     = Signed & A[DIV_WIDTH-1];
  assign sb     = Signed & B[DIV_WIDTH-1];
  assign a_mag  = neg_if(A, sa);
  assign b_mag  = neg_if(B, sb);
  assign res_lo = neg_if(quo, neg_q);
  assign res_hi = neg_if(rem, neg_r);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && Start) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = Signed;
  assign a_mag         = A;
  assign b_mag         = B;
  assign res_lo        = quo;
  assign res_hi        = rem;
`endif

  div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvsr),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (Start) state_nxt = b_zero ? DONE : CALC;
      CALC: if (cnt == 6'(DIV_ITER - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy    = (state != IDLE);
    Done    = (state == DONE);
    DivZero = (state == DONE) & dz;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvsr <= '0;
      dz   <= 1'b0;
      Lo   <= '0;
      Hi   <= '0;
    end else begin
      unique case (state)
        IDLE: if (Start) begin
          dz <= b_zero;
          if (!b_zero) begin
            cnt  <= '0;
            rem  <= '0;
            quo  <= a_mag;
            dvsr <= b_mag;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          Lo <= res_lo;
          Hi <= res_hi;
        end
        default: ;
      endcase
    end
  end

endmodule
